// File: rtl/imem_responder_pkg.sv
// Shared fetch-side definitions for the instruction memory responder.
//   XLEN          : architectural word width
//   NOP_INSTR     : canonical RV32 NOP (addi x0,x0,0), returned on faults
//   fetch_state_e : responder FSM encoding
package imem_responder_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: word-addressed array with a synchronous loader write
// port and an asynchronous read port that the responder FSM samples into its
// own response register.
// Ports:
//   clk             : rising-edge clock
//   we/wr_addr/...  : loader write (applied at the clock edge)
//   rd_addr/rd_data : combinational read of the currently stored word
// Storage is never reset.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A write and a sample on the same edge see the pre-write word because the
  // sampling register captures this value before the write lands.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch unit. Accepts one fetch request
// at a time, inserts WAIT_CYCLES wait states, then presents a held response
// until the fetch stage consumes it.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr      : fetch request (byte PC)
//   resp_valid/resp_ready             : response handshake
//   resp_instr/resp_pc/resp_err       : instruction, echoed PC, access fault
//   ld_we/ld_addr/ld_data             : program loader write port
//   busy                              : a request is in flight
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_instr,
  output logic [XLEN-1:0]   resp_pc,
  output logic              resp_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [XLEN-1:0]   ld_data,
  output logic              busy
);

  fetch_state_e    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            sample;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] rd_data;
  logic            fault;

  // With zero wait states the memory is sampled on the accept edge itself,
  // so the live request address is used; otherwise the captured PC is used.
  assign acc_addr = accept ? req_addr : resp_pc;

  assign fault = (acc_addr[1:0] != 2'b00) ||
                 ({2'b00, acc_addr[XLEN-1:2]} >= 32'(DEPTH_WORDS));

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk    (clk),
    .we     (ld_we),
    .wr_addr(ld_addr),
    .wr_data(ld_data),
    .rd_addr(acc_addr[ADDR_W+1:2]),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            sample  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Counter enters WAIT >= 1; the edge that takes it to 0 samples.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          sample  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      resp_instr <= '0;
      resp_pc    <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        resp_pc <= req_addr;
      end
      // Response data only changes on the sample edge, so it stays frozen
      // through RESP regardless of later loader writes.
      if (sample) begin
        resp_err   <= fault;
        resp_instr <= fault ? NOP_INSTR : rd_data;
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT with one wait state
  logic        rst1, req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1, ld_we1, busy1;
  logic [31:0] req_addr1, resp_instr1, resp_pc1, ld_data1;
  logic [9:0]  ld_addr1;
  // DUT with zero wait states
  logic        rst0, req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0, ld_we0, busy0;
  logic [31:0] req_addr0, resp_instr0, resp_pc0, ld_data0;
  logic [9:0]  ld_addr0;

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .ADDR_W(10)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_instr(resp_instr1), .resp_pc(resp_pc1), .resp_err(resp_err1),
    .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_data(ld_data1), .busy(busy1)
  );

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_addr(req_addr0), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_instr(resp_instr0), .resp_pc(resp_pc0), .resp_err(resp_err0),
    .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data0), .busy(busy0)
  );

  exp_t q1[$];
  exp_t q0[$];
  int   acc0_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- monitors / scoreboards ----------------
  initial begin : mon1
    int   acc_edge;
    logic prev_v;
    exp_t e;
    acc_edge = 0;
    prev_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        prev_v = 1'b0;
      end else begin
        if (req_valid1 && req_ready1) acc_edge = cyc + 1;
        if (resp_valid1 && !prev_v) chk("dut1 latency", 32'(cyc - acc_edge + 1), 32'd2);
        if (resp_valid1 && resp_ready1) begin
          if (q1.size() == 0) begin
            chk("dut1 unexpected response", 32'd1, 32'd0);
          end else begin
            e = q1.pop_front();
            chk("dut1 resp_instr", resp_instr1, e.instr);
            chk("dut1 resp_pc", resp_pc1, e.pc);
            chk("dut1 resp_err", 32'(resp_err1), 32'(e.err));
          end
        end
        prev_v = resp_valid1;
      end
    end
  end

  initial begin : mon0
    int   acc_edge;
    logic prev_v;
    exp_t e;
    acc_edge = 0;
    prev_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst0) begin
        prev_v = 1'b0;
      end else begin
        if (req_valid0 && req_ready0) begin
          acc_edge = cyc + 1;
          acc0_q.push_back(acc_edge);
        end
        if (resp_valid0 && !prev_v) chk("dut0 latency", 32'(cyc - acc_edge + 1), 32'd1);
        if (resp_valid0 && resp_ready0) begin
          if (q0.size() == 0) begin
            chk("dut0 unexpected response", 32'd1, 32'd0);
          end else begin
            e = q0.pop_front();
            chk("dut0 resp_instr", resp_instr0, e.instr);
            chk("dut0 resp_pc", resp_pc0, e.pc);
            chk("dut0 resp_err", 32'(resp_err0), 32'(e.err));
          end
        end
        prev_v = resp_valid0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_resp1();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid1 && resp_ready1) begin seen = 1'b1; break; end
    end
    if (!seen) chk("dut1 response timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp0();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid0 && resp_ready0) begin seen = 1'b1; break; end
    end
    if (!seen) chk("dut0 response timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic fetch1(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    q1.push_back('{instr: ei, pc: a, err: ee});
    req_addr1 = a; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    wait_resp1();
  endtask

  task automatic fetch0(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    q0.push_back('{instr: ei, pc: a, err: ee});
    req_addr0 = a; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    wait_resp0();
  endtask

  task automatic load_both(input logic [9:0] a, input logic [31:0] d);
    ld_we1 = 1'b1; ld_addr1 = a; ld_data1 = d;
    ld_we0 = 1'b1; ld_addr0 = a; ld_data0 = d;
    @(posedge clk); #1;
    ld_we1 = 1'b0; ld_we0 = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] prog [4];
  logic [31:0] stream_addr [3];

  initial begin : stim
    prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113;
    prog[2] = 32'h0030_0193; prog[3] = 32'h1111_1111;
    stream_addr[0] = 32'h0; stream_addr[1] = 32'h4; stream_addr[2] = 32'h8;

    rst1 = 1'b1; req_valid1 = 1'b0; req_addr1 = '0; resp_ready1 = 1'b1;
    ld_we1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
    rst0 = 1'b1; req_valid0 = 1'b0; req_addr0 = '0; resp_ready0 = 1'b1;
    ld_we0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;

    @(posedge clk); #1;
    // Program load happens while reset is held
    for (int i = 0; i < 4; i++) load_both(10'(i), prog[i]);

    @(negedge clk);
    chk("reset resp_valid", 32'(resp_valid1), 32'd0);
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset resp_instr", resp_instr1, 32'd0);
    chk("reset resp_pc", resp_pc1, 32'd0);
    chk("reset resp_err", 32'(resp_err1), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst0 = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", 32'(req_ready1), 32'd1);
    @(posedge clk); #1;

    // Basic fetches, one wait state
    fetch1(32'h0000_0000, 32'h0010_0093, 1'b0);
    fetch1(32'h0000_0002, NOP, 1'b1);
    fetch1(32'h0000_1000, NOP, 1'b1);
    fetch1(32'hFFFF_FFFC, NOP, 1'b1);
    fetch1(32'h0000_0004, 32'h0020_0113, 1'b0);

    // Back-pressure: hold resp_ready low for 3 cycles, meanwhile change
    // req_addr (must be ignored) and overwrite word 1 (response must stay).
    resp_ready1 = 1'b0;
    q1.push_back('{instr: 32'h0020_0113, pc: 32'h4, err: 1'b0});
    req_addr1 = 32'h4; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_addr1 = 32'h8;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (resp_valid1) begin seen = 1'b1; break; end
      end
      if (!seen) chk("hold response timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold resp_valid", 32'(resp_valid1), 32'd1);
      chk("hold resp_instr", resp_instr1, 32'h0020_0113);
      chk("hold resp_pc", resp_pc1, 32'h4);
      chk("hold req_ready", 32'(req_ready1), 32'd0);
      @(posedge clk); #1;
      if (i == 0) begin ld_we1 = 1'b1; ld_addr1 = 10'd1; ld_data1 = 32'hDEAD_BEEF; end
      if (i == 1) ld_we1 = 1'b0;
      if (i == 2) begin resp_ready1 = 1'b1; req_valid1 = 1'b0; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle after handshake req_ready", 32'(req_ready1), 32'd1);
    chk("idle after handshake busy", 32'(busy1), 32'd0);
    chk("idle after handshake resp_valid", 32'(resp_valid1), 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT aborts; loader still writes during reset
    req_addr1 = 32'h8; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; rst1 = 1'b1;
    ld_we1 = 1'b1; ld_addr1 = 10'd5; ld_data1 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort busy before reset edge", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    ld_we1 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("abort resp_instr", resp_instr1, 32'd0);
    chk("abort resp_pc", resp_pc1, 32'd0);
    chk("abort busy", 32'(busy1), 32'd0);
    chk("abort req_ready", 32'(req_ready1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("abort no resp_valid", 32'(resp_valid1), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    fetch1(32'h0000_0008, 32'h0030_0193, 1'b0);
    fetch1(32'h0000_0014, 32'hCAFE_F00D, 1'b0);

    // Zero wait states: streaming fetch with req_valid held high
    acc0_q.delete();
    req_valid0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr0 = stream_addr[k];
      q0.push_back('{instr: prog[k], pc: stream_addr[k], err: 1'b0});
      begin
        bit rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (req_ready0) begin rdy = 1'b1; break; end
        end
        if (!rdy) chk("stream req_ready timeout", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
    end
    req_valid0 = 1'b0;
    for (int i = 0; i < 20 && q0.size() != 0; i++) @(negedge clk);
    chk("stream drained", 32'(q0.size()), 32'd0);
    chk("stream accept count", 32'(acc0_q.size()), 32'd3);
    if (acc0_q.size() == 3) begin
      chk("stream spacing 0->1", 32'(acc0_q[1] - acc0_q[0]), 32'd2);
      chk("stream spacing 1->2", 32'(acc0_q[2] - acc0_q[1]), 32'd2);
    end
    @(posedge clk); #1;

    // Same-edge loader write and sample return the old word
    q0.push_back('{instr: 32'h1111_1111, pc: 32'hC, err: 1'b0});
    req_addr0 = 32'hC; req_valid0 = 1'b1;
    ld_we0 = 1'b1; ld_addr0 = 10'd3; ld_data0 = 32'h2222_2222;
    @(posedge clk); #1;
    req_valid0 = 1'b0; ld_we0 = 1'b0;
    wait_resp0();
    fetch0(32'h0000_000C, 32'h2222_2222, 1'b0);

    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("dut1 queue empty", 32'(q1.size()), 32'd0);
    chk("dut0 queue empty", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
